pipeline_hazard_ctrl: RTL and testbench

Parametrised pipeline sequencing controller for the in-order core. It generalises the fixed IF/ID/EXE enable generator to `STAGES` stages. It adds:
- per-stage stall requests with bubble insertion,
- branch/exception flush,
- per-stage valid tracking,
- a saturating stall-cycle counter and a stall watchdog.

It sits beside the datapath and drives the PC write enable and every inter-stage register enable.

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/sat_counter.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 86 ++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the in-order pipeline sequencing controller.
// The highest-set-bit encoder resolves the oldest stall and flush requester.
package pipe_ctrl_pkg;
  localparam int MAX_STAGES = 8;
  localparam int IDX_W      = 3;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EXE = 2;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } stage_sel_t;

  typedef struct packed {
    logic [MAX_STAGES-1:0] stall;
    logic [MAX_STAGES-1:0] flush;
  } hazard_req_t;

  // Older stages carry higher indices, so the highest set bit wins.
  function automatic stage_sel_t highest_set(input logic [MAX_STAGES-1:0] v);
    stage_sel_t r;
    r = '0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      if (v[i]) begin
        r.hit = 1'b1;
        r.idx = IDX_W'(i);
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Counter with a clear that takes effect before the increment in the same cycle,
// so clr && inc restarts the count at one. Optional saturation at all ones.
module sat_counter #(
  parameter int W   = 16,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] base;

  always_comb begin
    base = clr ? '0 : cnt;
  end

  always_ff @(posedge clk) begin
    if (inc && !(SAT && (&base))) cnt <= base + W'(1);
    else                          cnt <= base;
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stage enable / valid sequencer for an N-stage in-order pipeline with stall,
// flush, a saturating stall-cycle counter and a sticky stall watchdog.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES  = 3,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic [STAGES-1:0] stall_req,
  input  logic [STAGES-1:0] flush_req,
  output logic [STAGES-1:0] stage_ena,
  output logic [STAGES-1:0] stage_valid,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic              stall_timeout
);
  localparam int RUN_W = $clog2(TIMEOUT + 2);

  hazard_req_t       req;
  stage_sel_t        s_sel, f_sel, prev_s;
  logic              run, flush_hon, same_s, to_hit;
  logic [STAGES-1:0] valid_nxt;
  logic [RUN_W-1:0]  run_cnt, run_base;

  assign req.stall = MAX_STAGES'(stall_req);
  assign req.flush = MAX_STAGES'(flush_req);
  assign s_sel     = highest_set(req.stall);
  assign f_sel     = highest_set(req.flush);
  assign run       = ena && !reset;
  // A flush at or below the oldest stall is dropped, not deferred.
  assign flush_hon = f_sel.hit && (!s_sel.hit || (f_sel.idx > s_sel.idx));

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic above_s;
    assign above_s      = !s_sel.hit || (IDX_W'(k) > s_sel.idx);
    assign stage_ena[k] = run && above_s;
    if (k == 0) begin : g_fetch
      assign valid_nxt[k] = 1'b1;
    end else begin : g_reg
      logic bubble, killed;
      assign bubble       = s_sel.hit && (s_sel.idx == IDX_W'(k - 1));
      assign killed       = flush_hon && (IDX_W'(k) <= f_sel.idx);
      assign valid_nxt[k] = !killed &&
                            (above_s ? (!bubble && stage_valid[k-1]) : stage_valid[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)    stage_valid <= '0;
    else if (ena) stage_valid <= valid_nxt;
  end

  sat_counter #(.W(CNT_W), .SAT(1'b1)) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .inc (run && s_sel.hit),
    .cnt (stall_cycles)
  );

  // Run length restarts whenever the oldest stalling stage changes.
  always_ff @(posedge clk) begin
    if (reset)    prev_s <= '0;
    else if (ena) prev_s <= s_sel;
  end

  assign same_s   = prev_s.hit && (prev_s == s_sel);
  assign run_base = same_s ? run_cnt : '0;

  sat_counter #(.W(RUN_W), .SAT(1'b1)) u_run_cnt (
    .clk (clk),
    .clr (reset || (run && !same_s)),
    .inc (run && s_sel.hit),
    .cnt (run_cnt)
  );

  // The current cycle is stalled cycle number run_base+1 on this stage.
  assign to_hit = run && s_sel.hit && (int'(run_base) >= TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (reset)                         stall_timeout <= 1'b0;
    else if ((TIMEOUT != 0) && to_hit) stall_timeout <= 1'b1;
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus randomized bench for two controller configurations against a
// per-stage behavioural model of the valid/stall/flush rules.
module tb_pipeline_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset, ena;
  logic [2:0]  st3, fl3, ena3, val3;
  logic [3:0]  st4, fl4, ena4, val4;
  logic [15:0] cnt3;
  logic [2:0]  cnt4;
  logic        to3, to4;

  int tests = 0;
  int fails = 0;

  localparam int NS[2]   = '{3, 4};
  localparam int TOV[2]  = '{4, 6};
  localparam int CMAX[2] = '{65535, 7};

  int m_v[2][8];
  int m_cnt[2], m_run[2], m_prev[2], m_to[2];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.STAGES(3), .CNT_W(16), .TIMEOUT(4)) dut3 (
    .clk(clk), .reset(reset), .ena(ena), .stall_req(st3), .flush_req(fl3),
    .stage_ena(ena3), .stage_valid(val3), .stall_cycles(cnt3), .stall_timeout(to3));

  pipeline_hazard_ctrl #(.STAGES(4), .CNT_W(3), .TIMEOUT(6)) dut4 (
    .clk(clk), .reset(reset), .ena(ena), .stall_req(st4), .flush_req(fl4),
    .stage_ena(ena4), .stage_valid(val4), .stall_cycles(cnt4), .stall_timeout(to4));

  function automatic int top_bit(input logic [7:0] v);
    int r = -1;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [31:0] exp_ena(input int d, input logic [7:0] s_v,
                                          input logic en, input logic rs);
    logic [31:0] r = 0;
    int s = top_bit(s_v);
    if (en && !rs)
      for (int k = 0; k < NS[d]; k++) if (k > s) r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] pack_v(input int d);
    logic [31:0] r = 0;
    for (int k = 0; k < NS[d]; k++) r[k] = (m_v[d][k] != 0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_upd(input int d, input logic [7:0] s_v, input logic [7:0] f_v,
                           input logic en, input logic rs);
    int s, f;
    int nv[8];
    s = top_bit(s_v);
    f = top_bit(f_v);
    if (rs) begin
      for (int k = 0; k < 8; k++) m_v[d][k] = 0;
      m_cnt[d] = 0; m_run[d] = 0; m_prev[d] = -1; m_to[d] = 0;
      return;
    end
    if (!en) return;
    for (int k = 0; k < 8; k++) nv[k] = 0;
    nv[0] = 1;
    for (int k = 1; k < NS[d]; k++) begin
      if (k <= s)          nv[k] = m_v[d][k];
      else if (k == s + 1) nv[k] = 0;
      else                 nv[k] = m_v[d][k-1];
    end
    if (f > s) for (int k = 1; k <= f; k++) nv[k] = 0;
    for (int k = 0; k < 8; k++) m_v[d][k] = nv[k];
    if (s >= 0 && m_cnt[d] < CMAX[d]) m_cnt[d]++;
    if (s < 0)                m_run[d] = 0;
    else if (s == m_prev[d])  m_run[d]++;
    else                      m_run[d] = 1;
    m_prev[d] = s;
    if (TOV[d] != 0 && m_run[d] >= TOV[d]) m_to[d] = 1;
  endtask

  // One cycle: drive at negedge, check enables, clock, check registered state.
  task automatic step(input logic rs, input logic en, input logic [2:0] s3, input logic [2:0] f3,
                      input logic [3:0] s4, input logic [3:0] f4);
    reset = rs; ena = en; st3 = s3; fl3 = f3; st4 = s4; fl4 = f4;
    #1;
    check("ena3", ena3, exp_ena(0, {5'b0, s3}, en, rs));
    check("ena4", ena4, exp_ena(1, {4'b0, s4}, en, rs));
    model_upd(0, {5'b0, s3}, {5'b0, f3}, en, rs);
    model_upd(1, {4'b0, s4}, {4'b0, f4}, en, rs);
    @(posedge clk);
    #1;
    check("valid3", val3, pack_v(0));
    check("valid4", val4, pack_v(1));
    check("cnt3", cnt3, m_cnt[0]);
    check("cnt4", cnt4, m_cnt[1]);
    check("to3", to3, m_to[0]);
    check("to4", to4, m_to[1]);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; ena = 1'b0; st3 = '0; fl3 = '0; st4 = '0; fl4 = '0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 3'b010, 0, 4'b0100, 4'b1000);
    check("rst_valid3", val3, 3'b000);
    check("rst_to3", to3, 1'b0);

    // Fill
    step(0, 1, 0, 0, 0, 0);
    check("fill3_1", val3, 3'b001);
    step(0, 1, 0, 0, 0, 0);
    check("fill3_2", val3, 3'b011);
    step(0, 1, 0, 0, 0, 0);
    check("fill3_3", val3, 3'b111);
    step(0, 1, 0, 0, 0, 0);
    check("fill4", val4, 4'b1111);

    // Load-use on the 3-stage core
    step(0, 1, 3'b010, 0, 0, 0);
    check("lu_valid", val3, 3'b011);
    check("lu_cnt", cnt3, 16'd1);
    step(0, 1, 0, 0, 0, 0);

    // Flush from register 1 of the 4-stage core
    step(0, 1, 0, 0, 0, 4'b0010);
    check("flush_valid", val4, 4'b1101);
    repeat (3) step(0, 1, 0, 0, 0, 0);

    // Stall at 2 dominates flush at 1
    step(0, 1, 0, 0, 4'b0100, 4'b0010);
    check("stall_beats_flush", val4, 4'b0111);

    // Freeze in the middle of a stall, then resume
    step(0, 1, 3'b010, 0, 0, 0);
    step(0, 1, 3'b010, 0, 0, 0);
    check("pre_freeze_cnt", cnt3, 16'd3);
    repeat (3) step(0, 0, 3'b010, 3'b100, 4'b0001, 0);
    check("freeze_cnt", cnt3, 16'd3);
    check("freeze_to", to3, 1'b0);
    step(0, 1, 3'b010, 0, 0, 0);
    check("resume_to_early", to3, 1'b0);
    step(0, 1, 3'b010, 0, 0, 0);
    check("resume_to", to3, 1'b1);
    check("resume_cnt", cnt3, 16'd5);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    check("to_sticky", to3, 1'b1);

    // Reset clears the watchdog; alternating stall source never trips it
    step(1, 1, 3'b010, 3'b100, 0, 0);
    check("rst_clears_to", to3, 1'b0);
    for (int i = 0; i < 20; i++)
      step(0, 1, (i % 2) ? 3'b010 : 3'b100, 0, (i % 2) ? 4'b0010 : 4'b0100, 0);
    check("alt_to3", to3, 1'b0);
    check("alt_to4", to4, 1'b0);

    // Counter saturation and watchdog on the narrow-counter instance
    step(1, 0, 0, 0, 0, 0);
    repeat (8) step(0, 1, 0, 0, 4'b0001, 0);
    check("sat_cnt4", cnt4, 3'd7);
    check("wd_to4", to4, 1'b1);

    // Randomized traffic
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic        rs, en;
      logic [2:0]  s3, f3;
      logic [3:0]  s4, f4;
      rs = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 9) != 0);
      s3 = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      s4 = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      f4 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      step(rs, en, s3, f3, s4, f4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
